pc_sequencer: RTL and testbench

//  Fetch/branch sequencer that drives reg_pc's control side: push, pop, load, write_en, addr_in, data_in.

---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Sequencer bus: ROM word and datapath inputs, reg_pc control
//            strobes, and the execute-stage IR/stack status outputs.
// Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int INSTR_W     = 12,
  parameter int PC_W        = 9,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 2
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [INSTR_W-1:0] instr_in;
  logic               skip_cond;
  logic               pcl_write;
  logic [DATA_W-1:0]  alu_result;
  logic               pc_write_en;
  logic               pc_push;
  logic               pc_pop;
  logic               pc_load;
  logic [PC_W-1:0]    pc_addr;
  logic [DATA_W-1:0]  pc_data;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               retlw_en;
  logic [DATA_W-1:0]  retlw_lit;
  logic [LVL_W-1:0]   stack_level;
  logic               stack_ovf;
  logic               stack_undf;

  modport master (
    input  instr_in, skip_cond, pcl_write, alu_result,
    output pc_write_en, pc_push, pc_pop, pc_load, pc_addr, pc_data,
    output ir, ir_valid, retlw_en, retlw_lit, stack_level, stack_ovf, stack_undf
  );

  modport slave (
    output instr_in, skip_cond, pcl_write, alu_result,
    input  pc_write_en, pc_push, pc_pop, pc_load, pc_addr, pc_data,
    input  ir, ir_valid, retlw_en, retlw_lit, stack_level, stack_ovf, stack_undf
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch/branch sequencer driving reg_pc control; latches IR,
//            decodes GOTO/CALL/RETLW/skip/PCL writes and tracks stack depth.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int INSTR_W     = 12,
  parameter int PC_W        = 9,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  pc_sequencer_if.master       bus
);
  localparam int c_LVL_W = $clog2(STACK_DEPTH + 1);
  localparam logic [c_LVL_W-1:0] c_MAX_LVL = c_LVL_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_ir_valid;
  logic [c_LVL_W-1:0]   r_stack_level;
  logic                 r_stack_ovf;
  logic                 r_stack_undf;

  logic w_active;
  logic w_is_goto, w_is_call, w_is_retlw, w_is_skip;
  logic w_wr, w_push, w_pop, w_load, w_redirect;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_PRIME;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_is_goto  = (r_ir[INSTR_W-1 -: 3] == 3'b101);
    w_is_call  = (r_ir[INSTR_W-1 -: 4] == 4'b1001);
    w_is_retlw = (r_ir[INSTR_W-1 -: 4] == 4'b1000);
    // BTFSC/BTFSS share 011x; DECFSZ and INCFSZ are 001011 / 001111
    w_is_skip  = (r_ir[INSTR_W-1 -: 3] == 3'b011)
              || (r_ir[INSTR_W-1 -: 6] == 6'b001011)
              || (r_ir[INSTR_W-1 -: 6] == 6'b001111);

    w_active   = !reset && (r_state == ST_RUN) && r_ir_valid;
    w_wr       = w_active && bus.pcl_write;
    w_push     = w_active && !bus.pcl_write && w_is_call;
    w_pop      = w_active && !bus.pcl_write && !w_is_call && w_is_retlw;
    w_load     = w_active && !bus.pcl_write && !w_is_call && !w_is_retlw && w_is_goto;
    w_redirect = w_wr || w_push || w_pop || w_load
              || (w_active && w_is_skip && bus.skip_cond);

    w_state_nxt = r_state;
    case (r_state)
      ST_PRIME: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = w_redirect ? ST_FLUSH : ST_RUN;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir          <= '0;
      r_ir_valid    <= 1'b0;
      r_stack_level <= '0;
      r_stack_ovf   <= 1'b0;
      r_stack_undf  <= 1'b0;
    end else begin
      r_ir       <= bus.instr_in;
      // the word fetched alongside a redirect is the wrong path
      r_ir_valid <= !w_redirect;
      if (w_push) begin
        if (r_stack_level == c_MAX_LVL) r_stack_ovf   <= 1'b1;
        else                            r_stack_level <= r_stack_level + c_LVL_W'(1);
      end
      if (w_pop) begin
        if (r_stack_level == '0) r_stack_undf  <= 1'b1;
        else                     r_stack_level <= r_stack_level - c_LVL_W'(1);
      end
    end
  end

  assign bus.pc_write_en = w_wr;
  assign bus.pc_push     = w_push;
  assign bus.pc_pop      = w_pop;
  assign bus.pc_load     = w_load;
  assign bus.pc_addr     = r_ir[PC_W-1:0];
  assign bus.pc_data     = w_wr ? bus.alu_result : r_ir[DATA_W-1:0];
  assign bus.ir          = r_ir;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.retlw_en    = w_pop;
  assign bus.retlw_lit   = r_ir[DATA_W-1:0];
  assign bus.stack_level = r_stack_level;
  assign bus.stack_ovf   = r_stack_ovf;
  assign bus.stack_undf  = r_stack_undf;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Bench for pc_sequencer with a ROM, a reg_pc plant and an
//            instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_sequencer_if #(.INSTR_W(12), .PC_W(9), .DATA_W(8), .STACK_DEPTH(2)) bus ();

  pc_sequencer #(.INSTR_W(12), .PC_W(9), .DATA_W(8), .STACK_DEPTH(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Program ROM and a reg_pc stand-in with its 2-entry return stack
  logic [11:0] rom [0:511];
  logic [8:0]  r_pc;
  logic [8:0]  r_stk [0:1];
  assign bus.instr_in = rom[r_pc];

  always @(posedge clock) begin
    if (reset) begin
      r_pc <= 9'd0; r_stk[0] <= 9'd0; r_stk[1] <= 9'd0;
    end else if (bus.pc_write_en) begin
      r_pc <= {1'b0, bus.pc_data};
    end else if (bus.pc_push) begin
      r_stk[1] <= r_stk[0]; r_stk[0] <= r_pc; r_pc <= {1'b0, bus.pc_data};
    end else if (bus.pc_pop) begin
      r_pc <= r_stk[0]; r_stk[0] <= r_stk[1];
    end else if (bus.pc_load) begin
      r_pc <= bus.pc_addr;
    end else begin
      r_pc <= r_pc + 9'd1;
    end
  end

  // Reference model: instruction classes and what each one must cause
  typedef enum {K_PLAIN, K_GOTO, K_CALL, K_RETLW, K_SKIP} kind_t;
  typedef struct packed {
    logic       wr, push, pop, load;
    logic [8:0] addr;
    logic [7:0] data;
    logic       retlw_en;
    logic       redirect;
  } exp_t;

  logic [11:0] r_mdl_ir;
  logic        r_mdl_valid;
  logic        r_mdl_ovf, r_mdl_undf;
  bit          mdl_stk_q [$];

  function automatic kind_t classify(input logic [11:0] w);
    if (w[11:9] == 3'b101)  return K_GOTO;
    if (w[11:8] == 4'b1001) return K_CALL;
    if (w[11:8] == 4'b1000) return K_RETLW;
    if (w[11:8] == 4'b0110 || w[11:8] == 4'b0111 ||
        w[11:6] == 6'b001011 || w[11:6] == 6'b001111) return K_SKIP;
    return K_PLAIN;
  endfunction

  function automatic exp_t expect_now();
    exp_t  e;
    kind_t k;
    k = classify(r_mdl_ir);
    e = '0;
    e.addr = r_mdl_ir[8:0];
    e.data = r_mdl_ir[7:0];
    if (r_mdl_valid && !reset) begin
      if (bus.pcl_write) begin
        e.wr = 1'b1; e.data = bus.alu_result;
      end else begin
        case (k)
          K_CALL:  e.push = 1'b1;
          K_RETLW: begin e.pop = 1'b1; e.retlw_en = 1'b1; end
          K_GOTO:  e.load = 1'b1;
          default: ;
        endcase
      end
      e.redirect = e.wr | e.push | e.pop | e.load | ((k == K_SKIP) && bus.skip_cond);
    end
    return e;
  endfunction

  always @(posedge clock) begin : model
    exp_t e;
    e = expect_now();
    if (reset) begin
      r_mdl_ir <= 12'h000; r_mdl_valid <= 1'b0;
      r_mdl_ovf <= 1'b0; r_mdl_undf <= 1'b0;
      mdl_stk_q.delete();
    end else begin
      r_mdl_ir    <= bus.instr_in;
      r_mdl_valid <= !e.redirect;
      if (e.push) begin
        mdl_stk_q.push_front(1'b1);
        if (mdl_stk_q.size() > 2) begin
          void'(mdl_stk_q.pop_back());
          r_mdl_ovf <= 1'b1;
        end
      end
      if (e.pop) begin
        if (mdl_stk_q.size() == 0) r_mdl_undf <= 1'b1;
        else void'(mdl_stk_q.pop_front());
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always begin : compare
    exp_t e;
    @(negedge clock);
    #2;
    if (chk_en) begin
      e = expect_now();
      check("pc_write_en", bus.pc_write_en, e.wr);
      check("pc_push", bus.pc_push, e.push);
      check("pc_pop", bus.pc_pop, e.pop);
      check("pc_load", bus.pc_load, e.load);
      check("pc_addr", bus.pc_addr, e.addr);
      check("pc_data", bus.pc_data, e.data);
      check("retlw_en", bus.retlw_en, e.retlw_en);
      check("retlw_lit", bus.retlw_lit, r_mdl_ir[7:0]);
      check("ir", bus.ir, r_mdl_ir);
      check("ir_valid", bus.ir_valid, r_mdl_valid);
      check("stack_level", bus.stack_level, mdl_stk_q.size());
      check("stack_ovf", bus.stack_ovf, r_mdl_ovf);
      check("stack_undf", bus.stack_undf, r_mdl_undf);
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 12'h000;
  endtask

  // Holds reset for three cycles; returns 1 ns into the first cycle after release
  task automatic boot();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.pc_write_en, bus.pc_push, bus.pc_pop, bus.pc_load};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    bus.skip_cond  = 1'b0;
    bus.pcl_write  = 1'b0;
    bus.alu_result = 8'h00;
    clear_rom();
    repeat (3) cyc();
    chk_en = 1'b1;

    // Reset release with all-NOP ROM
    boot();
    check("t1_c1_valid", bus.ir_valid, 32'd0);
    check("t1_c1_pc", r_pc, 32'h000);
    check("t1_c1_strobes", strobes(), 32'd0);
    cyc(); #1;
    check("t1_c2_valid", bus.ir_valid, 32'd1);
    check("t1_c2_pc", r_pc, 32'h001);
    cyc(); #1;
    check("t1_c3_pc", r_pc, 32'h002);
    check("t1_c3_strobes", strobes(), 32'd0);

    // GOTO 0x1A5 at 0x004
    reset = 1'b1;
    clear_rom();
    rom[9'h004] = 12'hBA5;
    rom[9'h005] = 12'h1EE;
    rom[9'h1A5] = 12'h1A5;
    boot();
    repeat (5) cyc(); #1;
    check("goto_load", bus.pc_load, 32'd1);
    check("goto_addr", bus.pc_addr, 32'h1A5);
    cyc(); #1;
    check("goto_bubble_valid", bus.ir_valid, 32'd0);
    check("goto_bubble_load", bus.pc_load, 32'd0);
    cyc(); #1;
    check("goto_target_ir", bus.ir, 32'h1A5);
    check("goto_target_valid", bus.ir_valid, 32'd1);

    // CALL 0x40 at 0x010, RETLW 0x7E at 0x040
    reset = 1'b1;
    clear_rom();
    rom[9'h010] = 12'h940;
    rom[9'h011] = 12'h111;
    rom[9'h040] = 12'h87E;
    rom[9'h041] = 12'h1EE;
    boot();
    repeat (17) cyc(); #1;
    check("call_push", bus.pc_push, 32'd1);
    check("call_data", bus.pc_data, 32'h40);
    check("call_lvl0", bus.stack_level, 32'd0);
    cyc(); #1;
    check("call_lvl1", bus.stack_level, 32'd1);
    cyc(); #1;
    check("ret_pop", bus.pc_pop, 32'd1);
    check("ret_en", bus.retlw_en, 32'd1);
    check("ret_lit", bus.retlw_lit, 32'h7E);
    cyc(); #1;
    check("ret_lvl0", bus.stack_level, 32'd0);
    cyc(); #1;
    check("ret_resume_ir", bus.ir, 32'h111);
    check("ret_resume_pc", r_pc, 32'h012);

    // Three nested CALLs then three RETLWs
    reset = 1'b1;
    clear_rom();
    rom[9'h000] = 12'h920;
    rom[9'h020] = 12'h930;
    rom[9'h030] = 12'h940;
    rom[9'h040] = 12'h801;
    rom[9'h031] = 12'h802;
    rom[9'h021] = 12'h803;
    boot();
    repeat (4) cyc(); #1;
    check("nest_c5_lvl", bus.stack_level, 32'd2);
    check("nest_c5_ovf", bus.stack_ovf, 32'd0);
    repeat (2) cyc(); #1;
    check("nest_c7_lvl", bus.stack_level, 32'd2);
    check("nest_c7_ovf", bus.stack_ovf, 32'd1);
    repeat (4) cyc(); #1;
    check("nest_c11_lvl", bus.stack_level, 32'd0);
    cyc(); #1;
    check("nest_c12_pop", bus.pc_pop, 32'd1);
    check("nest_c12_undf", bus.stack_undf, 32'd0);
    cyc(); #1;
    check("nest_c13_undf", bus.stack_undf, 32'd1);
    check("nest_c13_ovf", bus.stack_ovf, 32'd1);

    // Skip taken: BTFSC at 0x002, DECFSZ at 0x006
    reset = 1'b1;
    clear_rom();
    rom[9'h002] = 12'h603;
    rom[9'h003] = 12'h1EE;
    rom[9'h004] = 12'h144;
    rom[9'h006] = 12'h2C5;
    rom[9'h007] = 12'h1EF;
    rom[9'h008] = 12'h148;
    bus.skip_cond = 1'b1;
    boot();
    repeat (3) cyc(); #1;
    check("skip_strobes", strobes(), 32'd0);
    check("skip_pc_before", r_pc, 32'h003);
    cyc(); #1;
    check("skip_bubble", bus.ir_valid, 32'd0);
    cyc(); #1;
    check("skip_next_ir", bus.ir, 32'h144);
    check("skip_pc_after", r_pc, 32'h005);
    repeat (4) cyc(); #1;
    check("decfsz_next_ir", bus.ir, 32'h148);

    // Skip not taken: no bubble
    reset = 1'b1;
    bus.skip_cond = 1'b0;
    boot();
    repeat (4) cyc(); #1;
    check("noskip_ir", bus.ir, 32'h1EE);
    check("noskip_valid", bus.ir_valid, 32'd1);

    // PCL write outranks CALL; PCL write during flush is ignored
    reset = 1'b1;
    clear_rom();
    rom[9'h002] = 12'h940;
    rom[9'h003] = 12'h1EE;
    rom[9'h033] = 12'h133;
    boot();
    repeat (3) cyc();
    bus.pcl_write = 1'b1;
    bus.alu_result = 8'h33;
    #1;
    check("pcl_wr", bus.pc_write_en, 32'd1);
    check("pcl_push", bus.pc_push, 32'd0);
    check("pcl_data", bus.pc_data, 32'h33);
    cyc(); #1;
    check("pcl_flush_wr", bus.pc_write_en, 32'd0);
    cyc();
    bus.pcl_write = 1'b0;
    #1;
    check("pcl_target_ir", bus.ir, 32'h133);
    check("pcl_lvl", bus.stack_level, 32'd0);

    // Reset while CALL is in IR gates the strobe
    boot();
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    check("rst_gate_push", bus.pc_push, 32'd0);
    cyc(); #1;
    check("rst_gate_lvl", bus.stack_level, 32'd0);

    // Reset on the cycle after a CALL discards the redirect
    boot();
    repeat (3) cyc(); #1;
    check("rst_call_push", bus.pc_push, 32'd1);
    cyc();
    reset = 1'b1;
    #1;
    check("rst_flush_strobes", strobes(), 32'd0);
    cyc(); #1;
    check("rst_after_lvl", bus.stack_level, 32'd0);
    check("rst_after_valid", bus.ir_valid, 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    check("rst_prime_valid", bus.ir_valid, 32'd0);
    cyc(); #1;
    check("rst_restart_ir", bus.ir, 32'h000);
    check("rst_restart_pc", r_pc, 32'h001);

    repeat (3) cyc();
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
